// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 MAR/MDR owner and memory handshake controller.
// Drives MDR onto the shared bus and reports access completion (R) and a sticky timeout.
module lc3_mem_ctrl #(
   parameter int          TIMEOUT  = 64,
   parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] bus_in,
   input  logic        ld_mar,
   input  logic        ld_mdr,
   input  logic        mio_en,
   input  logic        r_w,
   input  logic        gate_mdr,
   output logic [15:0] bus_out,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_req,
   output logic        mem_we,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic        r,
   output logic        err,
   output logic [15:0] mar,
   output logic [15:0] mdr
);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic timeout;

   assign bus_out = gate_mdr ? mdr : 16'bz;
   assign r       = (state == DONE);
   assign timeout = (state == ACCESS) && !mem_ready && (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = mio_en ? ACCESS : IDLE;
         ACCESS:  state_nx = (mem_ready || timeout) ? DONE : ACCESS;
         DONE:    state_nx = mio_en ? DONE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   // mem_we still holds the direction of the access while in ACCESS
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mar       <= '0;
         mdr       <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ld_mar) mar <= bus_in;
               if (ld_mdr && !mio_en) mdr <= bus_in;
               if (mio_en) begin
                  mem_addr  <= mar;
                  mem_wdata <= mdr;
                  mem_we    <= r_w;
                  mem_req   <= 1'b1;
                  cnt       <= '0;
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (!mem_we) mdr <= mem_rdata;
               end else if (timeout) begin
                  err     <= 1'b1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (!mem_we) mdr <= ERR_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Consumer-side partner of the bus drivers on the LC-3 datapath: owns MAR and MDR, loads them from the shared 16-bit data bus, and runs the memory read/write handshake.
- Gates MDR back onto the bus through a tri-state driver.
- Gives the control FSM the LC-3 "R" (memory ready) indication, plus a sticky timeout error.

Parameters:
- TIMEOUT, 64: max cycles in ACCESS waiting for mem_ready before abort; must be ≥2.
- ERR_DATA, 16'hDEAD: value loaded into MDR on a read timeout.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bus_in  input  16  shared data bus, sampled value.
- ld_mar  input  1  load MAR from bus_in.
- ld_mdr  input  1  load MDR from bus_in (only when mio_en=0).
- mio_en  input  1  start/hold memory access.
- r_w  input  1  0 = read, 1 = write; sampled at access start.
- gate_mdr  input  1  drive MDR onto bus_out.
- bus_out  output  16  MDR when gate_mdr=1, else all-Z (combinational).
- mem_addr  output  16  address latched at access start.
- mem_wdata  output  16  MDR latched at access start.
- mem_req  output  1  registered request, high throughout ACCESS.
- mem_we  output  1  registered write enable, valid with mem_req.
- mem_rdata  input  16  read data, valid when mem_ready=1.
- mem_ready  input  1  memory completion, one-cycle or held.
- r  output  1  access complete, high in DONE.
- err  output  1  sticky timeout flag.
- mar  output  16  current MAR (debug/observe).
- mdr  output  16  current MDR (debug/observe).

Behaviour:
- Reset (rst_n low, asynchronous):
  - mar=0, mdr=0, mem_addr=0, mem_wdata=0.
  - mem_req=0, mem_we=0, r=0, err=0.
  - Timeout counter=0, state=IDLE.
  - Reset mid-access abandons the access with no MDR update.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - ld_mar=1 → mar<=bus_in.
  - ld_mdr=1 with mio_en=0 → mdr<=bus_in.
  - mio_en=1 → latch mem_addr<=mar, mem_wdata<=mdr, mem_we<=r_w; set mem_req=1, counter=0; go to ACCESS.
  - Same-cycle ld_mar and mio_en: the access uses the old mar; mar still updates.
- ACCESS:
  - mem_req held high; mem_addr, mem_wdata and mem_we frozen.
  - ld_mar and ld_mdr are ignored.
  - mem_ready=1 → mem_req<=0, mem_we<=0; if read, mdr<=mem_rdata; go to DONE.
  - Otherwise the counter increments. When counter==TIMEOUT-1 with no mem_ready: err<=1, mem_req<=0; on a read mdr<=ERR_DATA; a write is dropped; go to DONE.
  - mio_en dropping during ACCESS is ignored; the access always completes or times out.
- DONE:
  - r=1.
  - Returns to IDLE on the first cycle mio_en=0. While mio_en stays 1, remain in DONE (no re-trigger).
- Latency: mio_en seen at edge N → mem_req high after N. mem_ready sampled at edge M → r high and mdr updated after M.
- Minimum access: 3 cycles mio_en-to-r when mem_ready is asserted in the first ACCESS cycle.
- err clears only on reset.
- bus_out is purely combinational from gate_mdr and mdr; it is never driven by the FSM.

Test Plan:
- Load then gate: bus_in=16'h3000 with ld_mar=1; bus_in=16'h1234 with ld_mdr=1; gate_mdr=1 → mar=3000, bus_out=1234; gate_mdr=0 → bus_out=ZZZZ.
- Read: mar=16'h3000, mio_en=1, r_w=0, memory returns 16'hBEEF with mem_ready 2 cycles after mem_req → mem_addr=3000, mem_we=0, mdr=BEEF, r high 1 cycle after mem_ready; deassert mio_en → IDLE.
- Write: mdr=16'hA5A5, mar=16'hFE06, r_w=1 → mem_req=1, mem_we=1, mem_addr=FE06, mem_wdata=A5A5; mem_ready → r=1; mdr stays A5A5.
- Frozen inputs: during ACCESS pulse ld_mar with bus_in=16'h4444 and ld_mdr → mem_addr unchanged, mar unchanged, mdr unchanged.
- Timeout: TIMEOUT=4, read, mem_ready never asserted → after 4 ACCESS cycles err=1, mdr=DEAD, mem_req=0, r=1; err stays 1 after return to IDLE.
- Reset mid-access: rst_n low during ACCESS → mem_req=0, r=0, mar=0, mdr=0 immediately, without waiting for a clock edge; after release, state is IDLE.
